// File: rtl/tempsens_pkg.sv
// rtl/tempsens_pkg.sv - shared FSM states, command default and frame constants for the tempsens host reader
package tempsens_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SEND_CMD = 3'd1,
        WAIT_LSB = 3'd2,
        WAIT_MSB = 3'd3,
        DONE     = 3'd4
    } state_t;

    localparam logic [7:0] DEFAULT_CMD_BYTE = 8'h01;

    // start + 8 data + stop
    localparam int FRAME_BITS = 10;
    localparam int BIT_IDX_W  = $clog2(FRAME_BITS);

    // 8N1 frame in transmission order, bit 0 first
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] data);
        return {1'b1, data, 1'b0};
    endfunction

endpackage

// File: rtl/tempsens_uart_rx.sv
// rtl/tempsens_uart_rx.sv - 8N1 serial receiver with synchronizer, mid-bit sampling and framing check
// clk, reset    : system clock, asynchronous active-low reset
// rx            : serial input, idle high, LSB first
// data / valid  : received byte, valid pulses one cycle when the stop bit is good
// frame_err     : one-cycle pulse when the stop bit is sampled low; the byte is dropped
module tempsens_uart_rx
    import tempsens_pkg::*;
#(
    parameter int DIV = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err
);

    localparam int                   CW        = $clog2(DIV);
    localparam logic [CW-1:0]        SAMPLE_AT = CW'(DIV / 2);
    localparam logic [CW-1:0]        LAST_CYC  = CW'(DIV - 1);
    localparam logic [BIT_IDX_W-1:0] STOP_IDX  = BIT_IDX_W'(FRAME_BITS - 1);

    logic                 rx_meta;
    logic                 rx_sync;
    logic                 rx_prev;
    logic                 fall;
    logic                 active;
    logic [CW-1:0]        cnt;
    logic [BIT_IDX_W-1:0] bit_idx;
    logic [7:0]           shreg;

    assign fall = rx_prev & ~rx_sync;

    // Synchronizer resets to the idle level so reset release never looks like a start edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active    <= 1'b0;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
            if (!active) begin
                // The edge-detect cycle is position 0 of the start bit.
                if (fall) begin
                    active  <= 1'b1;
                    cnt     <= CW'(1);
                    bit_idx <= '0;
                end
            end else begin
                if (cnt == LAST_CYC) begin
                    cnt     <= '0;
                    bit_idx <= bit_idx + 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                if (cnt == SAMPLE_AT) begin
                    if (bit_idx == '0) begin
                        // start bit gone high by mid-bit: treat as a glitch
                        if (rx_sync) begin
                            active <= 1'b0;
                        end
                    end else if (bit_idx == STOP_IDX) begin
                        // back to hunting at mid-stop so the next start edge is not missed
                        active <= 1'b0;
                        if (rx_sync) begin
                            data  <= shreg;
                            valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        shreg <= {rx_sync, shreg[7:1]};
                    end
                end
            end
        end
    end

endmodule

// File: rtl/tempsens_host_reader.sv
// rtl/tempsens_host_reader.sv - sends a measurement command and assembles a 16-bit reply; TEMPSENS_HOST_TIMEOUT_EN enables the response timeout
// clk, reset     : system clock, asynchronous active-low reset
// start          : request one transaction, honoured only in IDLE
// rx / tx        : 8N1 serial link to the sensor, idle high
// busy           : high while the FSM is out of IDLE
// result         : last measurement {MSB byte, LSB byte}
// result_valid   : one-cycle pulse while the new result is first presented
// timeout_err    : one-cycle pulse when a response byte does not arrive in time
module tempsens_host_reader
    import tempsens_pkg::*;
#(
    parameter int         CLK_FREQ    = 10000,
    parameter int         BAUD        = 1000,
    parameter logic [7:0] CMD_BYTE    = DEFAULT_CMD_BYTE,
    parameter int         TIMEOUT_CYC = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        rx,
    output logic        tx,
    output logic        busy,
    output logic [15:0] result,
    output logic        result_valid,
    output logic        timeout_err
);

    localparam int                    DIV       = CLK_FREQ / BAUD;
    localparam int                    CW        = $clog2(DIV);
    localparam logic [CW-1:0]         LAST_CYC  = CW'(DIV - 1);
    localparam logic [BIT_IDX_W-1:0]  STOP_IDX  = BIT_IDX_W'(FRAME_BITS - 1);
    localparam logic [FRAME_BITS-1:0] CMD_FRAME = build_frame(CMD_BYTE);

    state_t               state;
    state_t               next_state;
    logic [CW-1:0]        tx_cnt;
    logic [BIT_IDX_W-1:0] tx_bit;
    logic                 tx_frame_end;
    logic [7:0]           shadow;
    logic [7:0]           rx_data;
    logic                 rx_valid;
    logic                 rx_frame_err;
    logic                 rx_good;
    logic                 timeout_hit;

    tempsens_uart_rx #(
        .DIV (DIV)
    ) u_rx (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .data      (rx_data),
        .valid     (rx_valid),
        .frame_err (rx_frame_err)
    );

    // a framing error never qualifies a byte, whatever the receiver reports alongside it
    assign rx_good      = rx_valid & ~rx_frame_err;
    assign tx_frame_end = (state == SEND_CMD) && (tx_cnt == LAST_CYC) && (tx_bit == STOP_IDX);

    assign tx           = (state == SEND_CMD) ? CMD_FRAME[tx_bit] : 1'b1;
    assign busy         = (state != IDLE);
    assign result_valid = (state == DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = SEND_CMD;
                end
            end
            SEND_CMD: begin
                if (tx_frame_end) begin
                    next_state = WAIT_LSB;
                end
            end
            WAIT_LSB: begin
                if (rx_good) begin
                    next_state = WAIT_MSB;
                end else if (timeout_hit) begin
                    next_state = IDLE;
                end
            end
            WAIT_MSB: begin
                if (rx_good) begin
                    next_state = DONE;
                end else if (timeout_hit) begin
                    next_state = IDLE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // result is loaded on the edge into DONE, so it changes exactly when result_valid rises
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_cnt <= '0;
            tx_bit <= '0;
            shadow <= '0;
            result <= '0;
        end else begin
            if (state == SEND_CMD) begin
                if (tx_cnt == LAST_CYC) begin
                    tx_cnt <= '0;
                    tx_bit <= tx_bit + 1'b1;
                end else begin
                    tx_cnt <= tx_cnt + 1'b1;
                end
            end else begin
                tx_cnt <= '0;
                tx_bit <= '0;
            end
            if ((state == WAIT_LSB) && rx_good) begin
                shadow <= rx_data;
            end
            if ((state == WAIT_MSB) && rx_good) begin
                result <= {rx_data, shadow};
            end
        end
    end

`ifdef TEMPSENS_HOST_TIMEOUT_EN
    localparam int            TW      = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

    logic [TW-1:0] to_cnt;
    logic          in_wait;

    assign in_wait     = (state == WAIT_LSB) || (state == WAIT_MSB);
    // to_cnt holds the number of wait cycles already spent on the current byte
    assign timeout_hit = in_wait && !rx_good && (to_cnt == TO_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= timeout_hit;
            if (!in_wait || rx_good) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_tempsens_host_reader.sv
// tb/tb_tempsens_host_reader.sv - randomized self-checking bench for tempsens_host_reader
module tb_tempsens_host_reader;

    localparam int         CLK_FREQ    = 10000;
    localparam int         BAUD        = 1000;
    localparam int         DIV         = CLK_FREQ / BAUD;
    localparam int         TIMEOUT_CYC = 200;
    localparam logic [7:0] CMD         = 8'h01;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        rx    = 1'b1;
    logic        tx;
    logic        busy;
    logic [15:0] result;
    logic        result_valid;
    logic        timeout_err;

    int vectors     = 0;
    int miscompares = 0;

    tempsens_host_reader #(
        .CLK_FREQ    (CLK_FREQ),
        .BAUD        (BAUD),
        .CMD_BYTE    (CMD),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .rx           (rx),
        .tx           (tx),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    // pulse monitor
    int          rv_pulses     = 0;
    int          to_pulses     = 0;
    logic [15:0] rv_result     = '0;
    logic        busy_after_rv = 1'b1;
    logic        rv_d          = 1'b0;

    always @(negedge clk) begin
        if (rv_d) busy_after_rv <= busy;
        rv_d <= result_valid;
        if (result_valid) begin
            rv_pulses <= rv_pulses + 1;
            rv_result <= result;
        end
        if (timeout_err) to_pulses <= to_pulses + 1;
    end

    // reference model: a transaction is a list of bytes from the sensor; the first two
    // with a good stop bit form {second, first}, otherwise the result is untouched
    typedef struct {
        logic [7:0] data;
        bit         good;
    } rx_byte_t;

    rx_byte_t    txn_q[$];
    logic [15:0] model_result = '0;

    function automatic logic [15:0] model_expect(input logic [15:0] prev);
        logic [7:0] good_bytes[$];
        foreach (txn_q[i]) if (txn_q[i].good) good_bytes.push_back(txn_q[i].data);
        if (good_bytes.size() >= 2) return {good_bytes[1], good_bytes[0]};
        return prev;
    endfunction

    function automatic rx_byte_t mk(input logic [7:0] d, input bit g);
        rx_byte_t b;
        b.data = d;
        b.good = g;
        return b;
    endfunction

    function automatic logic [7:0] rnd8();
        return 8'($urandom_range(0, 255));
    endfunction

    task automatic send_byte(input logic [7:0] d, input bit good_stop);
        logic [9:0] bits;
        bits = {good_stop ? 1'b1 : 1'b0, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            repeat (DIV) @(negedge clk);
        end
        rx = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic play_txn();
        foreach (txn_q[i]) send_byte(txn_q[i].data, txn_q[i].good);
    endtask

    task automatic issue_cmd();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_frame();
        repeat (10 * DIV) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL reset_tx: got %b expected 1", tx); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
        vectors++; if (result !== 16'h0000) begin miscompares++; $display("FAIL reset_result: got %h expected 0000", result); end
        vectors++; if (result_valid !== 1'b0) begin miscompares++; $display("FAIL reset_result_valid: got %b expected 0", result_valid); end
        vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("FAIL reset_timeout_err: got %b expected 0", timeout_err); end
        reset = 1'b1;
        model_result = 16'h0000;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_cmd_frame();
        logic [7:0] cmd_v;
        logic       exp_tx;
        int         bad_tx;
        int         bad_busy;
        cmd_v    = CMD;
        bad_tx   = 0;
        bad_busy = 0;
        issue_cmd();
        for (int i = 0; i < 10 * DIV; i++) begin
            if (i < DIV) exp_tx = 1'b0;
            else if (i >= 9 * DIV) exp_tx = 1'b1;
            else exp_tx = cmd_v[i / DIV - 1];
            vectors++;
            if (tx !== exp_tx) begin
                miscompares++;
                if (bad_tx++ < 4) $display("FAIL cmd_frame_tx cycle %0d: got %b expected %b", i, tx, exp_tx);
            end
            vectors++;
            if (busy !== 1'b1) begin
                miscompares++;
                if (bad_busy++ < 4) $display("FAIL cmd_frame_busy cycle %0d: got %b expected 1", i, busy);
            end
            @(negedge clk);
        end
        vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL cmd_after_frame_tx: got %b expected 1", tx); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL cmd_after_frame_busy: got %b expected 1", busy); end
        txn_q = {};
        txn_q.push_back(mk(rnd8(), 1'b1));
        txn_q.push_back(mk(rnd8(), 1'b1));
        play_txn();
        repeat (5) @(negedge clk);
        model_result = model_expect(model_result);
    endtask

    // runs one commanded transaction from txn_q and checks its outcome
    task automatic run_and_check(input string name);
        int          rv_base;
        logic [15:0] exp;
        int          exp_pulses;
        rv_base    = rv_pulses;
        exp        = model_expect(model_result);
        exp_pulses = (exp !== model_result || model_expect(16'h0000) !== 16'h0000 ||
                      model_expect(16'hffff) !== 16'hffff) ? 1 : 0;
        issue_cmd();
        wait_frame();
        play_txn();
        repeat (5) @(negedge clk);
        #1;
        vectors++; if (rv_pulses - rv_base !== exp_pulses) begin miscompares++; $display("FAIL %s_pulses: got %0d expected %0d", name, rv_pulses - rv_base, exp_pulses); end
        vectors++; if (result !== exp) begin miscompares++; $display("FAIL %s_result: got %h expected %h", name, result, exp); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL %s_busy_end: got %b expected 0", name, busy); end
        if (exp_pulses == 1) begin
            vectors++; if (rv_result !== exp) begin miscompares++; $display("FAIL %s_result_at_valid: got %h expected %h", name, rv_result, exp); end
            vectors++; if (busy_after_rv !== 1'b0) begin miscompares++; $display("FAIL %s_busy_after_valid: got %b expected 0", name, busy_after_rv); end
        end
        model_result = exp;
    endtask

    task automatic test_transaction();
        for (int t = 0; t < 5; t++) begin
            txn_q = {};
            if (t == 0) begin
                txn_q.push_back(mk(8'h34, 1'b1));
                txn_q.push_back(mk(8'h12, 1'b1));
            end else begin
                txn_q.push_back(mk(rnd8(), 1'b1));
                txn_q.push_back(mk(rnd8(), 1'b1));
            end
            run_and_check("txn");
        end
    endtask

    task automatic test_framing_error();
        txn_q = {};
        txn_q.push_back(mk(8'h34, 1'b1));
        txn_q.push_back(mk(8'h12, 1'b0));
        txn_q.push_back(mk(8'h56, 1'b1));
        run_and_check("framing");
        vectors++; if (result !== 16'h5634) begin miscompares++; $display("FAIL framing_literal: got %h expected 5634", result); end
        txn_q = {};
        txn_q.push_back(mk(rnd8(), 1'b0));
        txn_q.push_back(mk(rnd8(), 1'b1));
        txn_q.push_back(mk(rnd8(), 1'b0));
        txn_q.push_back(mk(rnd8(), 1'b1));
        run_and_check("framing_rand");
    endtask

    task automatic test_glitch();
        int          rv_base;
        logic [15:0] exp;
        rv_base = rv_pulses;
        txn_q = {};
        txn_q.push_back(mk(rnd8(), 1'b1));
        txn_q.push_back(mk(rnd8(), 1'b1));
        exp = model_expect(model_result);
        issue_cmd();
        wait_frame();
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (3 * DIV) @(negedge clk);
        play_txn();
        repeat (5) @(negedge clk);
        #1;
        vectors++; if (rv_pulses - rv_base !== 1) begin miscompares++; $display("FAIL glitch_pulses: got %0d expected 1", rv_pulses - rv_base); end
        vectors++; if (result !== exp) begin miscompares++; $display("FAIL glitch_result: got %h expected %h", result, exp); end
        model_result = exp;
    endtask

    task automatic test_idle_bytes();
        int rv_base;
        rv_base = rv_pulses;
        send_byte(rnd8(), 1'b1);
        send_byte(rnd8(), 1'b1);
        repeat (5) @(negedge clk);
        #1;
        vectors++; if (rv_pulses - rv_base !== 0) begin miscompares++; $display("FAIL idle_bytes_pulses: got %0d expected 0", rv_pulses - rv_base); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL idle_bytes_busy: got %b expected 0", busy); end
        vectors++; if (result !== model_result) begin miscompares++; $display("FAIL idle_bytes_result: got %h expected %h", result, model_result); end
    endtask

    task automatic test_start_ignored();
        int          low_cycles;
        int          rv_base;
        logic [15:0] exp;
        low_cycles = 0;
        rv_base    = rv_pulses;
        txn_q = {};
        txn_q.push_back(mk(rnd8(), 1'b1));
        txn_q.push_back(mk(rnd8(), 1'b1));
        exp = model_expect(model_result);
        issue_cmd();
        wait_frame();
        repeat (20) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 12 * DIV; i++) begin
            if (tx !== 1'b1) low_cycles++;
            @(negedge clk);
        end
        vectors++; if (low_cycles !== 0) begin miscompares++; $display("FAIL restart_tx_low_cycles: got %0d expected 0", low_cycles); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL restart_busy: got %b expected 1", busy); end
        play_txn();
        repeat (5) @(negedge clk);
        #1;
        vectors++; if (rv_pulses - rv_base !== 1) begin miscompares++; $display("FAIL restart_pulses: got %0d expected 1", rv_pulses - rv_base); end
        vectors++; if (result !== exp) begin miscompares++; $display("FAIL restart_result: got %h expected %h", result, exp); end
        model_result = exp;
    endtask

`ifdef TEMPSENS_HOST_TIMEOUT_EN
    task automatic test_timeout();
        int first;
        int to_base;
        to_base = to_pulses;
        first   = -1;
        issue_cmd();
        wait_frame();
        for (int k = 0; k < TIMEOUT_CYC + 60; k++) begin
            if (first < 0 && timeout_err === 1'b1) first = k;
            @(negedge clk);
        end
        #1;
        vectors++; if (first < TIMEOUT_CYC - 1 || first > TIMEOUT_CYC + 1) begin miscompares++; $display("FAIL timeout_lsb_cycle: got %0d expected %0d", first, TIMEOUT_CYC); end
        vectors++; if (to_pulses - to_base !== 1) begin miscompares++; $display("FAIL timeout_lsb_pulses: got %0d expected 1", to_pulses - to_base); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL timeout_lsb_busy: got %b expected 0", busy); end
        vectors++; if (result !== model_result) begin miscompares++; $display("FAIL timeout_lsb_result: got %h expected %h", result, model_result); end
        to_base = to_pulses;
        issue_cmd();
        wait_frame();
        send_byte(rnd8(), 1'b1);
        repeat (TIMEOUT_CYC + 60) @(negedge clk);
        #1;
        vectors++; if (to_pulses - to_base !== 1) begin miscompares++; $display("FAIL timeout_msb_pulses: got %0d expected 1", to_pulses - to_base); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL timeout_msb_busy: got %b expected 0", busy); end
        vectors++; if (result !== model_result) begin miscompares++; $display("FAIL timeout_msb_result: got %h expected %h", result, model_result); end
    endtask
`else
    task automatic test_timeout();
        int to_base;
        to_base = to_pulses;
        issue_cmd();
        wait_frame();
        repeat (TIMEOUT_CYC + 100) @(negedge clk);
        #1;
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL wait_forever_busy: got %b expected 1", busy); end
        vectors++; if (to_pulses - to_base !== 0) begin miscompares++; $display("FAIL wait_forever_timeout: got %0d expected 0", to_pulses - to_base); end
        txn_q = {};
        txn_q.push_back(mk(rnd8(), 1'b1));
        txn_q.push_back(mk(rnd8(), 1'b1));
        play_txn();
        repeat (5) @(negedge clk);
        #1;
        vectors++; if (result !== model_expect(model_result)) begin miscompares++; $display("FAIL wait_forever_result: got %h expected %h", result, model_expect(model_result)); end
        model_result = model_expect(model_result);
    endtask
`endif

    task automatic test_reset_mid();
        int         rv_base;
        logic [7:0] d;
        // abort during the command frame
        issue_cmd();
        repeat (35) @(negedge clk);
        reset = 1'b0;
        #1;
        vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL midtx_reset_tx: got %b expected 1", tx); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midtx_reset_busy: got %b expected 0", busy); end
        vectors++; if (result !== 16'h0000) begin miscompares++; $display("FAIL midtx_reset_result: got %h expected 0000", result); end
        model_result = 16'h0000;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL midtx_release_tx: got %b expected 1", tx); end
        // abort in the middle of a received byte
        issue_cmd();
        wait_frame();
        d = rnd8();
        rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = d[i];
            repeat (DIV) @(negedge clk);
        end
        reset = 1'b0;
        rx    = 1'b1;
        #1;
        vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL midrx_reset_tx: got %b expected 1", tx); end
        vectors++; if (result_valid !== 1'b0) begin miscompares++; $display("FAIL midrx_reset_valid: got %b expected 0", result_valid); end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        rv_base = rv_pulses;
        repeat (15 * DIV) @(negedge clk);
        #1;
        vectors++; if (rv_pulses - rv_base !== 0) begin miscompares++; $display("FAIL midrx_stale_pulses: got %0d expected 0", rv_pulses - rv_base); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midrx_busy: got %b expected 0", busy); end
        vectors++; if (result !== 16'h0000) begin miscompares++; $display("FAIL midrx_result: got %h expected 0000", result); end
        txn_q = {};
        txn_q.push_back(mk(rnd8(), 1'b1));
        txn_q.push_back(mk(rnd8(), 1'b1));
        run_and_check("after_reset");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, vectors %0d", vectors);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_cmd_frame();
        test_transaction();
        test_framing_error();
        test_glitch();
        test_idle_bytes();
        test_start_ignored();
        test_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
